// File: rtl/d_ff_reset_test_if.sv
// Data bundle for d_ff_reset_test: one shared input and the five differently-reset outputs.
// The master drives i_value and observes the outputs; the slave is the register block.
interface d_ff_reset_test_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] i_value;
  logic [WIDTH-1:0] o_value_sync_reset;
  logic [WIDTH-1:0] o_value_async_reset;
  logic [WIDTH-1:0] o_value_async_reset_n;
  logic [WIDTH-1:0] o_value_mixed_reset;
  logic [WIDTH-1:0] o_value_no_reset;

  modport master (
    output i_value,
    input  o_value_sync_reset,
    input  o_value_async_reset,
    input  o_value_async_reset_n,
    input  o_value_mixed_reset,
    input  o_value_no_reset
  );

  modport slave (
    input  i_value,
    output o_value_sync_reset,
    output o_value_async_reset,
    output o_value_async_reset_n,
    output o_value_mixed_reset,
    output o_value_no_reset
  );

endinterface

// File: rtl/d_ff_reset_test.sv
// Five parallel D registers on one input, each with a different reset style (reset-style fixture).
// Optional macro D_FF_TEST_RST_SYNC_EN adds 2-flop synchronizers on async_reset_n / async_reset release.
module d_ff_reset_test #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                clk,
  input  logic                async_reset_n,
  input  logic                async_reset,
  input  logic                sync_reset,
  d_ff_reset_test_if.slave    bus
);

  logic             rst_n_int;
  logic             rst_int;
  logic [WIDTH-1:0] value_sync_reset;
  logic [WIDTH-1:0] value_async_reset;
  logic [WIDTH-1:0] value_async_reset_n;
  logic [WIDTH-1:0] value_mixed_reset;
  logic [WIDTH-1:0] value_no_reset;

`ifdef D_FF_TEST_RST_SYNC_EN
  // Assert immediately, release only after two clk edges so deassertion is clean.
  logic [1:0] rst_n_sync;
  logic [1:0] rst_sync;

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) rst_n_sync <= 2'b00;
    else                rst_n_sync <= {rst_n_sync[0], 1'b1};
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) rst_sync <= 2'b11;
    else             rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_n_int = rst_n_sync[1];
  assign rst_int   = rst_sync[1];
`else
  assign rst_n_int = async_reset_n;
  assign rst_int   = async_reset;
`endif

  always_ff @(posedge clk) begin
    if (sync_reset) value_sync_reset <= RESET_VALUE;
    else            value_sync_reset <= bus.i_value;
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) value_async_reset <= RESET_VALUE;
    else         value_async_reset <= bus.i_value;
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) value_async_reset_n <= RESET_VALUE;
    else            value_async_reset_n <= bus.i_value;
  end

  // Async clear wins; the synchronous reset is only seen at an edge.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int)      value_mixed_reset <= RESET_VALUE;
    else if (sync_reset) value_mixed_reset <= RESET_VALUE;
    else                 value_mixed_reset <= bus.i_value;
  end

  always_ff @(posedge clk) begin
    value_no_reset <= bus.i_value;
  end

  assign bus.o_value_sync_reset    = value_sync_reset;
  assign bus.o_value_async_reset   = value_async_reset;
  assign bus.o_value_async_reset_n = value_async_reset_n;
  assign bus.o_value_mixed_reset   = value_mixed_reset;
  assign bus.o_value_no_reset      = value_no_reset;

endmodule

// File: tb/tb_d_ff_reset_test.sv
// Directed bench for d_ff_reset_test: hand-computed expectations for each reset style.
// Honors D_FF_TEST_RST_SYNC_EN by expecting release to take effect on the 3rd edge.
module tb_d_ff_reset_test;

  localparam int WIDTH = 1;
`ifdef D_FF_TEST_RST_SYNC_EN
  localparam int RELEASE_EDGES = 3;
`else
  localparam int RELEASE_EDGES = 1;
`endif

  logic clk           = 1'b0;
  logic clk_en        = 1'b0;
  logic async_reset_n = 1'b1;
  logic async_reset   = 1'b0;
  logic sync_reset    = 1'b0;
  int   n_checks      = 0;
  int   n_bad         = 0;

  d_ff_reset_test_if #(.WIDTH(WIDTH)) bus ();

  d_ff_reset_test #(
    .WIDTH       (WIDTH),
    .RESET_VALUE ({WIDTH{1'b0}})
  ) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .async_reset   (async_reset),
    .sync_reset    (sync_reset),
    .bus           (bus)
  );

  // 100 MHz clock that can be held stopped
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", n_checks, n_bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [WIDTH-1:0] observed,
                              input logic [WIDTH-1:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e_sync, input logic e_async,
                           input logic e_async_n, input logic e_mixed, input logic e_none);
    check_output({tag, "_sync"},    bus.o_value_sync_reset,    {WIDTH{e_sync}});
    check_output({tag, "_async"},   bus.o_value_async_reset,   {WIDTH{e_async}});
    check_output({tag, "_async_n"}, bus.o_value_async_reset_n, {WIDTH{e_async_n}});
    check_output({tag, "_mixed"},   bus.o_value_mixed_reset,   {WIDTH{e_mixed}});
    check_output({tag, "_none"},    bus.o_value_no_reset,      {WIDTH{e_none}});
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic value, input logic srst, input logic arst,
                                input logic arst_n);
    bus.i_value   = {WIDTH{value}};
    sync_reset    = srst;
    async_reset   = arst;
    async_reset_n = arst_n;
  endtask

  initial begin
    $display("[TB] start, release edges = %0d", RELEASE_EDGES);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #10;

    // All three resets pulsed with the clock stopped
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check_output("stopped_async",   bus.o_value_async_reset,   '0);
    check_output("stopped_async_n", bus.o_value_async_reset_n, '0);
    check_output("stopped_mixed",   bus.o_value_mixed_reset,   '0);
    #9;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    #5;
    clk_en = 1'b1;
    wait_edges(RELEASE_EDGES);
    check_all("start", 1, 1, 1, 1, 1);

    // Synchronous reset across one edge
    @(negedge clk) sync_reset = 1'b1;
    wait_edges(1);
    check_all("srst", 0, 1, 1, 0, 1);
    @(negedge clk) sync_reset = 1'b0;
    wait_edges(1);
    check_output("srst_rel_sync",  bus.o_value_sync_reset,  '1);
    check_output("srst_rel_mixed", bus.o_value_mixed_reset, '1);

    // Active-low async reset asserted mid-cycle
    @(negedge clk);
    #2 async_reset_n = 1'b0;
    #1 check_all("arstn", 1, 1, 0, 0, 1);
    wait_edges(1);
    check_output("arstn_held_async_n", bus.o_value_async_reset_n, '0);
    check_output("arstn_held_mixed",   bus.o_value_mixed_reset,   '0);
    @(negedge clk) async_reset_n = 1'b1;
`ifdef D_FF_TEST_RST_SYNC_EN
    wait_edges(1);
    check_output("arstn_rel_e1", bus.o_value_async_reset_n, '0);
    wait_edges(1);
    check_output("arstn_rel_e2", bus.o_value_async_reset_n, '0);
    wait_edges(1);
    check_output("arstn_rel_e3",       bus.o_value_async_reset_n, '1);
    check_output("arstn_rel_e3_mixed", bus.o_value_mixed_reset,   '1);
`else
    wait_edges(1);
    check_output("arstn_rel_e1",       bus.o_value_async_reset_n, '1);
    check_output("arstn_rel_e1_mixed", bus.o_value_mixed_reset,   '1);
`endif

    // Active-high async reset asserted mid-cycle
    @(negedge clk);
    #2 async_reset = 1'b1;
    #1 check_all("arst", 1, 0, 1, 1, 1);
    @(negedge clk) async_reset = 1'b0;
    wait_edges(RELEASE_EDGES);
    check_output("arst_rel", bus.o_value_async_reset, '1);

    // Sync and active-high async together: each register sees only its own reset
    @(negedge clk) begin
      sync_reset  = 1'b1;
      async_reset = 1'b1;
    end
    wait_edges(1);
    check_all("combo", 0, 0, 1, 0, 1);
    @(negedge clk) begin
      sync_reset  = 1'b0;
      async_reset = 1'b0;
    end
    wait_edges(RELEASE_EDGES);
    check_all("combo_rel", 1, 1, 1, 1, 1);

    // Data toggles 1->0->1, one-cycle latency
    @(negedge clk) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    #1 check_all("pre_edge", 1, 1, 1, 1, 1);
    wait_edges(1);
    check_all("data0", 0, 0, 0, 0, 0);
    @(negedge clk) bus.i_value = '1;
    wait_edges(1);
    check_all("data1", 1, 1, 1, 1, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/d_ff_reset_test.md
Name: d_ff_reset_test

Overview:
- Reference block that holds one data input in five parallel D flip-flop registers, each using a different reset style.
- Styles: synchronous active-high, asynchronous active-high, asynchronous active-low, mixed (async active-low plus sync active-high), and no reset.
- Used as a characterisation and lint fixture for the reset styles allowed in the codebase. Instantiated stand-alone under a bench or in FPGA bring-up builds.

Parameters:
- WIDTH, 1, bit width of i_value and of every o_value_* output.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded by every reset path.

Ports:
- clk  input  1  single rising-edge clock; may be gated or stopped externally.
- async_reset_n  input  1  primary reset. One clock; reset is asynchronous and active-low. Also drives the mixed register.
- async_reset  input  1  asynchronous active-high reset; only for o_value_async_reset.
- sync_reset  input  1  synchronous active-high reset; for o_value_sync_reset and o_value_mixed_reset.
- i_value  input  WIDTH  data captured by all five registers.
- o_value_sync_reset  output  WIDTH  register with synchronous reset.
- o_value_async_reset  output  WIDTH  register with active-high asynchronous reset.
- o_value_async_reset_n  output  WIDTH  register with active-low asynchronous reset.
- o_value_mixed_reset  output  WIDTH  register with both async_reset_n and sync_reset.
- o_value_no_reset  output  WIDTH  register with no reset.

Behaviour:
- Every register captures i_value on the clk rising edge when its reset is inactive. Latency is 1 cycle. No enable input.
- o_value_sync_reset
  - At a rising edge with sync_reset=1, loads RESET_VALUE.
  - Ignores async_reset and async_reset_n.
  - Holds its value while clk is stopped, even if sync_reset is high.
- o_value_async_reset
  - Goes to RESET_VALUE immediately on async_reset=1, with no clock needed.
  - Held at RESET_VALUE while async_reset=1; captures again from the first edge after release.
  - Ignores sync_reset and async_reset_n.
- o_value_async_reset_n
  - Same as o_value_async_reset but controlled by async_reset_n=0.
  - Ignores the other resets.
- o_value_mixed_reset
  - async_reset_n=0 clears it asynchronously and has priority.
  - Otherwise sync_reset=1 at a rising edge loads RESET_VALUE.
  - Otherwise captures i_value.
  - Ignores async_reset.
- o_value_no_reset
  - Captures i_value on every edge.
  - Power-up value is undefined (X in simulation) until the first edge.
  - No reset input affects it.
- Before its first reset or clock edge, every output is undefined.
- All registers are independent. Simultaneous assertion of several resets affects each register only through its own reset(s).
- Release of an asynchronous reset coincident with a clock edge: the register stays at RESET_VALUE for that edge and captures on the next edge.

Optional Feature:
- Macro: D_FF_TEST_RST_SYNC_EN.
- When defined:
  - async_reset_n and async_reset each pass through a 2-flop reset synchronizer clocked by clk.
  - Assertion is still immediate (asynchronous).
  - Deassertion reaches the registers only after 2 rising clk edges.
  - The affected registers therefore capture i_value from the 3rd edge after release.
  - Synchronizer flops reset to the asserted state.
- When not defined: resets connect directly to the registers, and release takes effect at the next edge.

Test Plan:
- Clock stopped, i_value=1; pulse sync_reset=1, async_reset=1, async_reset_n=0 together for 10 ns.
  - o_value_async_reset, o_value_async_reset_n and o_value_mixed_reset go to 0 with no edge.
  - o_value_sync_reset and o_value_no_reset stay X.
- Release the resets, start a 100 MHz clk, i_value=1 → all five outputs read 1 after the first rising edge.
- sync_reset=1 across one rising edge → o_value_sync_reset=0 and o_value_mixed_reset=0; the other three stay 1. After release, both return to 1 on the next edge.
- async_reset_n=0 mid-cycle while sync_reset=0 → o_value_async_reset_n and o_value_mixed_reset drop to 0 immediately; the others hold 1.
- i_value toggles 1→0→1 on successive edges with no reset → every output follows with 1-cycle latency.
- With D_FF_TEST_RST_SYNC_EN defined, release async_reset_n → o_value_async_reset_n stays 0 for 2 edges and reads 1 after the 3rd edge.
